// File: rtl/hazard_stall_controller.sv
// Load-use / branch / memory-wait stall and flush control for the 5-stage pipe.
// Also keeps saturating perf counters and a sticky memory-timeout flag.
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_usesRs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_memRead,
  input  logic             EX_branchTaken,
  input  logic             EX_MEM_memAccess,
  input  logic             dmem_ready,
  input  logic             counter_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] loaduse_stalls,
  output logic [CNT_W-1:0] branch_flushes,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [7:0]       WMAX = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] lu_q, lu_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mw_q, mw_d;

  logic mem_stall, load_use;
  logic rule_mem, rule_br, rule_lu;

  assign mem_stall = EX_MEM_memAccess & ~dmem_ready;
  assign load_use  = ID_EX_memRead & (ID_EX_rd != 5'd0) &
                     ((ID_EX_rd == IF_ID_rs1) |
                      (IF_ID_usesRs2 & (ID_EX_rd == IF_ID_rs2)));

  // Reset forces the pipe into a flushed, frozen-PC state.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;
    rule_mem     = 1'b0;
    rule_br      = 1'b0;
    rule_lu      = 1'b0;
    priority case (1'b1)
      rst: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      mem_stall: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        pipe_hold   = 1'b1;
        rule_mem    = 1'b1;
      end
      EX_branchTaken: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        rule_br      = 1'b1;
      end
      load_use: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        rule_lu      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          wait_d = (wait_q >= WMAX) ? WMAX : wait_q + 8'd1;
        end else begin
          state_d = RUN;
          wait_d  = 8'd0;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
    tmo_d = tmo_q | (wait_d == WMAX);
  end

  always_comb begin
    lu_d = lu_q;
    br_d = br_q;
    mw_d = mw_q;
    if (counter_clr) begin
      lu_d = '0;
      br_d = '0;
      mw_d = '0;
    end else begin
      if (rule_lu && lu_q != CMAX) lu_d = lu_q + 1'b1;
      if (rule_br && br_q != CMAX) br_d = br_q + 1'b1;
      if (rule_mem && mw_q != CMAX) mw_d = mw_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      tmo_q   <= 1'b0;
      lu_q    <= '0;
      br_q    <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      lu_q    <= lu_d;
      br_q    <= br_d;
      mw_q    <= mw_d;
    end
  end

  assign mem_timeout     = tmo_q;
  assign loaduse_stalls  = lu_q;
  assign branch_flushes  = br_q;
  assign mem_wait_cycles = mw_q;

endmodule
